// File: rtl/regfile_sweep_engine.sv
// Fill/dump sweep engine for the 16x16 register file port set.
// Fill writes an arithmetic sequence; dump reads registers out over a valid/ready port.
module regfile_sweep_engine #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] fill_base,
    input  logic [15:0] fill_step,
    input  logic        abort,
    output logic [3:0]  rf_src_reg,
    input  logic [15:0] rf_src_data,
    output logic [3:0]  rf_dst_reg,
    output logic        rf_write,
    output logic [15:0] rf_dst_data,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [15:0] dump_data,
    output logic [3:0]  dump_idx,
    output logic        busy,
    output logic        done
);

    // state      | meaning
    // S_IDLE     | waiting for start
    // S_FILL     | one register written per cycle
    // S_DUMP_RD  | read select driven, data captured at next edge
    // S_DUMP_OUT | dump word held until handshake
    // S_DONE     | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_DUMP_RD,
        S_DUMP_OUT,
        S_DONE
    } state_t;

    localparam logic [3:0] FIRST_IDX = 4'(FIRST_REG);
    localparam logic [3:0] LAST_IDX  = 4'(LAST_REG);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] step_q, step_d;
    logic [3:0]  rf_src_reg_q, rf_src_reg_d;
    logic [3:0]  rf_dst_reg_q, rf_dst_reg_d;
    logic        rf_write_q, rf_write_d;
    logic [15:0] rf_dst_data_q, rf_dst_data_d;
    logic        dump_valid_q, dump_valid_d;
    logic [15:0] dump_data_q, dump_data_d;
    logic [3:0]  dump_idx_q, dump_idx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // In FILL, idx_q/acc_q mirror the register and value being written this cycle.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        acc_d         = acc_q;
        step_d        = step_q;
        rf_src_reg_d  = rf_src_reg_q;
        rf_dst_reg_d  = rf_dst_reg_q;
        rf_write_d    = 1'b0;
        rf_dst_data_d = rf_dst_data_q;
        dump_valid_d  = dump_valid_q;
        dump_data_d   = dump_data_q;
        dump_idx_d    = dump_idx_q;
        busy_d        = busy_q;
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d  = FIRST_IDX;
                    acc_d  = fill_base;
                    step_d = fill_step;
                    busy_d = 1'b1;
                    if (mode) begin
                        state_d       = S_FILL;
                        rf_write_d    = 1'b1;
                        rf_dst_reg_d  = FIRST_IDX;
                        rf_dst_data_d = fill_base;
                    end else begin
                        state_d      = S_DUMP_RD;
                        rf_src_reg_d = FIRST_IDX;
                    end
                end
            end
            S_FILL: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d         = idx_q + 4'd1;
                    acc_d         = acc_q + step_q;
                    rf_write_d    = 1'b1;
                    rf_dst_reg_d  = idx_q + 4'd1;
                    rf_dst_data_d = acc_q + step_q;
                end
            end
            S_DUMP_RD: begin
                dump_data_d  = rf_src_data;
                dump_idx_d   = idx_q;
                dump_valid_d = 1'b1;
                state_d      = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (dump_valid_q && dump_ready) begin
                    dump_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d        = idx_q + 4'd1;
                        rf_src_reg_d = idx_q + 4'd1;
                        state_d      = S_DUMP_RD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort wins over any handshake; the write already on the pins still lands.
        if (abort && state_q != S_IDLE) begin
            state_d      = S_IDLE;
            rf_write_d   = 1'b0;
            dump_valid_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            idx_q         <= FIRST_IDX;
            acc_q         <= '0;
            step_q        <= '0;
            rf_src_reg_q  <= '0;
            rf_dst_reg_q  <= '0;
            rf_write_q    <= 1'b0;
            rf_dst_data_q <= '0;
            dump_valid_q  <= 1'b0;
            dump_data_q   <= '0;
            dump_idx_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            step_q        <= step_d;
            rf_src_reg_q  <= rf_src_reg_d;
            rf_dst_reg_q  <= rf_dst_reg_d;
            rf_write_q    <= rf_write_d;
            rf_dst_data_q <= rf_dst_data_d;
            dump_valid_q  <= dump_valid_d;
            dump_data_q   <= dump_data_d;
            dump_idx_q    <= dump_idx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign rf_src_reg  = rf_src_reg_q;
    assign rf_dst_reg  = rf_dst_reg_q;
    assign rf_write    = rf_write_q;
    assign rf_dst_data = rf_dst_data_q;
    assign dump_valid  = dump_valid_q;
    assign dump_data   = dump_data_q;
    assign dump_idx    = dump_idx_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: doc/regfile_sweep_engine.md
Name: regfile_sweep_engine

Overview:
- Initiator-side engine for the 16x16 register file port set: drives the read-select, write-select, write-enable and write-data pins, and consumes read data.
- Two sweep operations, each covering registers FIRST_REG..LAST_REG in order:
  - Fill: writes an arithmetic sequence into the registers.
  - Dump: reads each register and streams it out over a valid/ready port.
- Used for post-reset register initialisation and for debug/testbench state dumps, on the register file's write/read pins in parallel with the core datapath.

Parameters:
FIRST_REG, 0, first register index swept (0..15)
LAST_REG, 15, last register index swept (FIRST_REG..15)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-low
start  input  1  one-cycle command strobe, sampled only in IDLE
mode  input  1  0 = dump, 1 = fill; sampled with start
fill_base  input  16  first fill value; sampled with start
fill_step  input  16  fill increment; sampled with start
abort  input  1  cancel current sweep
rf_src_reg  output  4  register file read select (SrcReg1 pin)
rf_src_data  input  16  register file read data (SrcData1 pin), combinational from rf_src_reg
rf_dst_reg  output  4  register file write select
rf_write  output  1  register file write enable
rf_dst_data  output  16  register file write data
dump_valid  output  1  dump word available
dump_ready  input  1  sink accepts dump word
dump_data  output  16  dumped register value
dump_idx  output  4  index of dumped register
busy  output  1  sweep in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst low, asynchronous): every output is 0, state = IDLE, idx = FIRST_REG, accumulator = 0.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, FILL, DUMP_RD, DUMP_OUT, DONE.
- IDLE:
  - start=1 latches mode, fill_base and fill_step; sets idx = FIRST_REG and acc = fill_base.
  - Next state is FILL if mode=1, DUMP_RD if mode=0.
  - start outside IDLE is ignored.
- FILL:
  - Each cycle drives rf_write=1, rf_dst_reg=idx, rf_dst_data=acc; the write takes effect at the following edge.
  - Then idx+1 and acc = acc + fill_step (mod 2^16, wrap silently).
  - After the write to LAST_REG, next state is DONE.
  - Fill length = LAST_REG-FIRST_REG+1 cycles. With defaults, register i receives fill_base + (i * fill_step) mod 2^16.
- DUMP_RD:
  - Drives rf_src_reg=idx.
  - At the next edge captures rf_src_data into dump_data and idx into dump_idx, sets dump_valid=1, goes to DUMP_OUT.
- DUMP_OUT:
  - dump_valid, dump_data and dump_idx are held stable until dump_valid && dump_ready at a rising edge.
  - On that handshake: dump_valid=0. If idx==LAST_REG, next state is DONE; else idx+1 and next state is DUMP_RD.
  - Minimum 2 cycles per register.
- rf_write=0 in every state except FILL. rf_src_reg holds its last value outside DUMP_RD.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy = 1 in FILL, DUMP_RD, DUMP_OUT and DONE; 0 in IDLE.
- Abort:
  - abort=1 in any non-IDLE state forces IDLE at the next edge.
  - Clears rf_write, dump_valid and busy. No done pulse.
  - A write driven in the abort cycle still completes. Registers already written keep their values.
  - abort has priority over a simultaneous handshake. abort in IDLE has no effect.
- FIRST_REG == LAST_REG: single-register sweep. Fill is 1 cycle, then DONE.
- Reset mid-sweep: immediate return to reset values. Partially filled registers are not restored.
- Register-file coherency: reading a register written in the same cycle is not this block's concern. Fill never reads; dump never writes.

Test Plan:
- Reset then fill: rst released, start=1, mode=1, fill_base=0x0010, fill_step=0x0001 -> rf_write high 16 consecutive cycles; writes 0x0010..0x001F to regs 0..15; done pulses exactly one cycle after the last write; busy low afterwards.
- Fill wrap: fill_base=0xFFFE, fill_step=0x0001 -> reg0=0xFFFE, reg1=0xFFFF, reg2=0x0000, reg15=0x000D.
- Dump with ready always 1, after the fill above: 16 handshakes, dump_idx 0..15 in order, dump_data 0x0010..0x001F; 32 cycles from start to done.
- Dump backpressure: dump_ready=0 for 5 cycles on idx 3 -> dump_valid, dump_data=0x0013 and dump_idx=3 stable throughout; idx 4 is presented only after the handshake; no word lost or duplicated.
- Abort: abort during fill at idx 7 -> regs 0..7 written (the abort-cycle write included), regs 8..15 unchanged; busy=0 next cycle; no done pulse. A start during busy is ignored.
- Async reset mid-dump with dump_valid=1: rst low between edges -> dump_valid, busy and rf_write drop to 0 immediately; a new start after release begins at FIRST_REG.
